// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port image SRAM between the BMP
// loader/dumper (port A) and the edge filter engine (port B).
// Round-robin arbitration with a bounded hold count; read data returns one
// cycle after the accepted read, steered to the port that issued it.
// Optional feature macro: ARB_STATS_EN adds saturating per-port wait counters.
module sram_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       a_wait_cnt,
    output logic [15:0]       b_wait_cnt
`endif
);

    localparam logic [1:0] ST_NONE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    logic [1:0]        state_q, state_d;
    logic              last_b_q, last_b_d;      // 1: last owner was B
    logic [3:0]        hold_cnt_q, hold_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_tag_b_q, rd_tag_b_d;  // 1: pending read belongs to B
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              gnt_a, gnt_b;

    // Pick this cycle's winner from the registered owner state and live requests.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        case (state_q)
            ST_OWN_A: begin
                if (a_req) begin
                    if (b_req && hold_cnt_q == HOLD_MAX) gnt_b = 1'b1;
                    else                                 gnt_a = 1'b1;
                end else begin
                    gnt_b = b_req;
                end
            end
            ST_OWN_B: begin
                if (b_req) begin
                    if (a_req && hold_cnt_q == HOLD_MAX) gnt_a = 1'b1;
                    else                                 gnt_b = 1'b1;
                end else begin
                    gnt_a = a_req;
                end
            end
            default: begin
                // Idle (and the unused encoding): a tie goes to the port opposite the last owner.
                if (a_req && b_req) begin
                    gnt_a = last_b_q;
                    gnt_b = ~last_b_q;
                end else begin
                    gnt_a = a_req;
                    gnt_b = b_req;
                end
            end
        endcase
        // No access may reach the SRAM while reset is asserted.
        if (rst) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end
    end

    assign a_gnt = gnt_a;
    assign b_gnt = gnt_b;

    // Steer the winner's address, data and write strobe onto the SRAM pins.
    always_comb begin
        sram_wen  = 1'b1;
        sram_addr = '0;
        sram_d    = '0;
        if (gnt_a) begin
            sram_wen  = ~a_we;
            sram_addr = a_addr;
            sram_d    = a_wdata;
        end else if (gnt_b) begin
            sram_wen  = ~b_we;
            sram_addr = b_addr;
            sram_d    = b_wdata;
        end
    end

    // Next owner, last owner, hold count and pending-read tag.
    always_comb begin
        state_d    = ST_NONE;
        last_b_d   = last_b_q;
        hold_cnt_d = '0;
        if (gnt_a) begin
            state_d  = ST_OWN_A;
            last_b_d = 1'b0;
            if (state_q != ST_OWN_A)                   hold_cnt_d = 4'd1;
            else if (b_req && hold_cnt_q < HOLD_MAX)   hold_cnt_d = hold_cnt_q + 4'd1;
            else                                       hold_cnt_d = hold_cnt_q;
        end else if (gnt_b) begin
            state_d  = ST_OWN_B;
            last_b_d = 1'b1;
            if (state_q != ST_OWN_B)                   hold_cnt_d = 4'd1;
            else if (a_req && hold_cnt_q < HOLD_MAX)   hold_cnt_d = hold_cnt_q + 4'd1;
            else                                       hold_cnt_d = hold_cnt_q;
        end
        rd_pend_d  = (gnt_a && !a_we) || (gnt_b && !b_we);
        rd_tag_b_d = gnt_b;
    end

    // Return read data to its owner; each port's rdata holds between pulses.
    assign a_rvalid  = rd_pend_q && !rd_tag_b_q;
    assign b_rvalid  = rd_pend_q &&  rd_tag_b_q;
    assign a_rdata   = a_rvalid ? sram_q : a_rdata_q;
    assign b_rdata   = b_rvalid ? sram_q : b_rdata_q;
    assign a_rdata_d = a_rdata;
    assign b_rdata_d = b_rdata;

    // Arbiter state registers; reset cancels any pending read return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_NONE;
            last_b_q   <= 1'b1;
            hold_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_tag_b_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            hold_cnt_q <= hold_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_tag_b_q <= rd_tag_b_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] a_wait_q, a_wait_d;
    logic [15:0] b_wait_q, b_wait_d;

    // Count cycles each port spends requesting without a grant, saturating.
    always_comb begin
        a_wait_d = a_wait_q;
        b_wait_d = b_wait_q;
        if (a_req && !gnt_a && a_wait_q != 16'hFFFF) a_wait_d = a_wait_q + 16'd1;
        if (b_req && !gnt_b && b_wait_q != 16'hFFFF) b_wait_d = b_wait_q + 16'd1;
    end

    // Wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_wait_q <= '0;
            b_wait_q <= '0;
        end else begin
            a_wait_q <= a_wait_d;
            b_wait_q <= b_wait_d;
        end
    end

    assign a_wait_cnt = a_wait_q;
    assign b_wait_cnt = b_wait_q;
`endif

endmodule
